// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared encodings, MSHR entry type and tag-width helper for dcache_nb
package dcache_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  // Per-entry control state; the line address is held alongside at its parametrised width.
  typedef struct packed {
    logic       valid;
    logic       drop;
    logic [3:0] mem_tag;
  } mshr_meta_t;

  function automatic int tag_bits_of(input int addr_bits, input int idx_bits);
    return addr_bits - 3 - idx_bits;
  endfunction

endpackage

// File: rtl/dcache_mshr.sv
// rtl/dcache_mshr.sv - miss status table: line CAM, memory-tag CAM, lowest-free allocation
module dcache_mshr
  import dcache_pkg::*;
#(
  parameter int LINE_BITS  = 26,
  parameter int MSHR_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [LINE_BITS-1:0] lookup_line,
  input  logic [3:0]           ret_tag,
  input  logic                 alloc_en,
  input  logic [3:0]           alloc_tag,
  input  logic                 drop_en,
  output logic                 line_match,
  output logic                 full,
  output logic                 fill_hit,
  output logic                 fill_drop,
  output logic [LINE_BITS-1:0] fill_line
);

  mshr_meta_t           meta      [MSHR_DEPTH];
  logic [LINE_BITS-1:0] line_addr [MSHR_DEPTH];

  logic [MSHR_DEPTH-1:0] valid_vec, line_eq, tag_eq, alloc_eq, drop_vec, free_vec, free_onehot;
  logic                  do_alloc;

  always_comb begin
    valid_vec = '0;
    line_eq   = '0;
    tag_eq    = '0;
    alloc_eq  = '0;
    drop_vec  = '0;
    fill_line = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      valid_vec[i] = meta[i].valid;
      drop_vec[i]  = meta[i].drop;
      line_eq[i]   = meta[i].valid && (line_addr[i] == lookup_line);
      tag_eq[i]    = meta[i].valid && (ret_tag != 4'd0) && (meta[i].mem_tag == ret_tag);
      alloc_eq[i]  = meta[i].valid && (meta[i].mem_tag == alloc_tag);
      // Valid mem_tags are unique, so at most one entry contributes here.
      fill_line    = fill_line | (tag_eq[i] ? line_addr[i] : '0);
    end
  end

  assign free_vec    = ~valid_vec;
  assign free_onehot = free_vec & (~free_vec + MSHR_DEPTH'(1));
  assign full        = &valid_vec;
  assign line_match  = |line_eq;
  assign fill_hit    = |tag_eq;
  assign fill_drop   = |(tag_eq & drop_vec);
  assign do_alloc    = alloc_en && !(|alloc_eq);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        meta[i]      <= '0;
        line_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        if (tag_eq[i]) begin
          meta[i] <= '0;
        end else if (do_alloc && free_onehot[i]) begin
          meta[i]      <= '{valid: 1'b1, drop: 1'b0, mem_tag: alloc_tag};
          line_addr[i] <= lookup_line;
        end else if (drop_en && line_eq[i]) begin
          meta[i].drop <= 1'b1;
        end
      end
    end
  end

  // Memory must never hand out a tag that is still outstanding.
  assert property (@(posedge clock) disable iff (reset) !(alloc_en && (|alloc_eq)));

endmodule

// File: rtl/dcache_nb.sv
// rtl/dcache_nb.sv - non-blocking data-cache controller: request/response steering around the MSHR table
module dcache_nb
  import dcache_pkg::*;
#(
  parameter  int IDX_BITS   = 5,
  parameter  int ADDR_BITS  = 32,
  parameter  int MSHR_DEPTH = 4,
  localparam int TAG_BITS   = tag_bits_of(ADDR_BITS, IDX_BITS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [63:0]         proc2dcache_addr,
  input  logic [1:0]          proc2dcache_command,
  input  logic [63:0]         proc2dcache_data,
  input  logic [63:0]         dcachemem_data,
  input  logic                dcachemem_valid,
  input  logic [3:0]          dmem2proc_response,
  input  logic [63:0]         dmem2proc_data,
  input  logic [3:0]          dmem2proc_tag,
  output logic [1:0]          proc2dmem_command,
  output logic [63:0]         proc2dmem_addr,
  output logic [63:0]         proc2dmem_data,
  output logic [63:0]         dcache_data_out,
  output logic                dcache_valid_out,
  output logic                dcache_stall,
  output logic [IDX_BITS-1:0] rd_index,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic                store_write_enable,
  output logic [IDX_BITS-1:0] store_index,
  output logic [TAG_BITS-1:0] store_tag,
  output logic                fill_write_enable,
  output logic [IDX_BITS-1:0] fill_index,
  output logic [TAG_BITS-1:0] fill_tag,
  output logic [63:0]         fill_data
);

  localparam int LINE_BITS = TAG_BITS + IDX_BITS;

  logic [LINE_BITS-1:0] cur_line, fill_line;
  logic is_load, is_store, accepted, line_match, full, fill_hit, fill_drop;
  logic load_hit, bypass, load_miss, issue, alloc_en, store_ok, store_kill;
  logic unused_addr_bits;

  assign cur_line          = proc2dcache_addr[ADDR_BITS-1:3];
  assign {rd_tag, rd_index} = cur_line;
  assign unused_addr_bits  = ^proc2dcache_addr[2:0];

  assign is_load  = !reset && (proc2dcache_command == BUS_LOAD);
  assign is_store = !reset && (proc2dcache_command == BUS_STORE);
  assign accepted = (dmem2proc_response != 4'd0);

  // Storage hit beats bypass; bypass beats every miss path.
  assign load_hit  = is_load && dcachemem_valid;
  assign bypass    = is_load && !dcachemem_valid && fill_hit && (fill_line == cur_line);
  assign load_miss = is_load && !dcachemem_valid && !bypass;
  assign issue     = load_miss && !line_match && !full;
  assign alloc_en  = issue && accepted;

  assign store_ok   = is_store && accepted;
  assign store_kill = store_ok && fill_hit && (fill_line == cur_line);

  dcache_mshr #(
    .LINE_BITS  (LINE_BITS),
    .MSHR_DEPTH (MSHR_DEPTH)
  ) u_mshr (
    .clock       (clock),
    .reset       (reset),
    .lookup_line (cur_line),
    .ret_tag     (dmem2proc_tag),
    .alloc_en    (alloc_en),
    .alloc_tag   (dmem2proc_response),
    .drop_en     (store_ok),
    .line_match  (line_match),
    .full        (full),
    .fill_hit    (fill_hit),
    .fill_drop   (fill_drop),
    .fill_line   (fill_line)
  );

  assign proc2dmem_command = issue ? BUS_LOAD : (is_store ? BUS_STORE : BUS_NONE);
  assign proc2dmem_addr    = {proc2dcache_addr[63:3], 3'b000};
  assign proc2dmem_data    = proc2dcache_data;

  assign dcache_valid_out = load_hit || bypass;
  assign dcache_data_out  = load_hit ? dcachemem_data : (bypass ? dmem2proc_data : 64'd0);
  assign dcache_stall     = load_miss || (is_store && !accepted);

  assign store_write_enable = store_ok;
  assign store_index        = rd_index;
  assign store_tag          = rd_tag;

  assign fill_write_enable     = !reset && fill_hit && !fill_drop && !store_kill;
  assign {fill_tag, fill_index} = fill_line;
  assign fill_data             = dmem2proc_data;

endmodule

// File: doc/dcache_nb.md
# dcache_nb

Non-blocking, parametrised data-cache controller sitting between the processor load/store port, the data-cache storage array and the tagged memory bus. It generalises the single-miss controller with a configurable index width and address width, plus an MSHR table tracking up to MSHR_DEPTH outstanding line misses by memory tag. The table adds secondary-miss merging, a hit-under-miss fill bypass, and store/fill ordering protection. Storage itself stays external.

## Interface
- IDX_BITS, 5, cache index width (lines = 2^IDX_BITS)
- ADDR_BITS, 32, significant address bits; TAG_BITS = ADDR_BITS-3-IDX_BITS
- MSHR_DEPTH, 4, outstanding misses tracked (2..15)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- proc2dcache_addr  in  64  byte address (8-byte lines)
- proc2dcache_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
- proc2dcache_data  in  64  store data
- dcachemem_data / dcachemem_valid  in  64/1  storage lookup result for rd_index/rd_tag
- dmem2proc_response  in  4  same-cycle accept tag, 0 = rejected
- dmem2proc_data / dmem2proc_tag  in  64/4  returning data, tag 0 = none
- proc2dmem_command / proc2dmem_addr / proc2dmem_data  out  2/64/64  memory request
- dcache_data_out / dcache_valid_out  out  64/1  load result
- dcache_stall  out  1  processor must hold its request
- rd_index / rd_tag  out  IDX_BITS/TAG_BITS  lookup address
- store_write_enable / store_index / store_tag  out  1/IDX_BITS/TAG_BITS  storage store port
- fill_write_enable / fill_index / fill_tag / fill_data  out  1/IDX_BITS/TAG_BITS/64  storage fill port

## Operation
- {rd_tag, rd_index} = proc2dcache_addr[ADDR_BITS-1:3]; proc2dmem_addr = {addr[63:3],3'b0}; proc2dmem_data = proc2dcache_data.
- MSHR entry: valid, drop, line address (TAG_BITS+IDX_BITS), mem_tag (4).
- Load hit: dcachemem_valid -> dcache_valid_out=1, data = dcachemem_data; no memory request.
- Fill bypass: tag match on a valid entry whose line equals the current load line -> dcache_valid_out=1, data = dmem2proc_data (overrides a storage miss).
- Load miss, line matches a valid entry (merge): no request, dcache_stall=1.
- Load miss, no match, free entry: proc2dmem_command=BUS_LOAD. Response !=0 -> allocate lowest-index free entry {line, response, drop=0}; dcache_stall=1 either way.
- Load miss, table full: command BUS_NONE, dcache_stall=1.
- Store: proc2dmem_command=BUS_STORE unconditionally. Response !=0 -> store_write_enable=1. A valid entry with the same line gets drop=1. Response 0 -> dcache_stall=1, no enables.
- Fill: dmem2proc_tag !=0 matching valid entry -> entry freed. fill_write_enable=1 with the entry's index/tag and dmem2proc_data unless drop=1; a dropped fill is freed silently. Unmatched or zero tags are ignored.
- Command BUS_NONE: all request/enable outputs 0, dcache_valid_out=0.

## Timing
- All outputs combinational from inputs and registered table. Table updates on the rising clock edge.
- Hit and bypass latency 0 cycles. Miss request is issued in the same cycle the command is first presented (no address-stable wait).
- Fill free and allocation in the same cycle both commit. Allocation picks from the pre-edge free set, so a slot freed this cycle is usable next cycle.
- Store and fill to the same line in the same cycle: the store wins. fill_write_enable=0 and the entry is freed.
- Accepted tag equal to a valid entry's mem_tag (memory protocol violation): no allocation, assertion fires.
- Reset: all entries invalid, drop=0. While reset is high, every enable, dcache_valid_out and dcache_stall is 0 and proc2dmem_command=BUS_NONE. Reset mid-miss abandons entries; later fills with old tags are ignored.

## Structure
- Shared package dcache_pkg: BUS_* encodings, MSHR entry typedef, TAG_BITS derivation function.
- Sub-module dcache_mshr: entry array, line-address CAM, mem-tag CAM, lowest-free priority encoder, full flag. The top level holds only request/response steering.

## Test plan
- Reset, then load 0x1000 with dcachemem_valid=1 -> valid_out same cycle, proc2dmem_command=BUS_NONE, no entry allocated.
- Load 0x1000 miss with response 3; data returned with tag 3 five cycles later -> fill_write_enable=1, fill_index=0x00, fill_tag=0x10, valid_out=1 via bypass in that cycle.
- Misses to 0x1000, 0x2000, 0x3000, 0x4000 accepted as tags 1..4, then a fifth miss to 0x5000 -> BUS_NONE and stall. Tag 2 returns -> 0x5000 is issued the following cycle.
- Outstanding miss to 0x1008 (tag 5), second load to 0x1008 -> no new request; store to 0x1008 accepted -> store_write_enable=1; tag 5 returns -> fill_write_enable=0, entry freed.
- Load miss with response 0 for three cycles, then 7 -> BUS_LOAD repeated every cycle, exactly one entry allocated with tag 7.
- Reset asserted with two entries valid, then tags of those entries returned -> no fill_write_enable, table empty.
